semaphore_read_responder: RTL and testbench

SEMAPHORE_READ_RESPONDER -- requirements
Module: semaphore_read_responder

---
 rtl/semaphore_pkg.sv | 19 +
 rtl/semaphore_rr_arbiter.sv | 29 ++
 rtl/semaphore_read_responder.sv | 152 +++++++++++++++
 tb/tb_semaphore_read_responder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/semaphore_pkg.sv
// Shared definitions for the semaphore read path: FSM encodings, field widths
// and the slot-count helper used to size the semaphore-side buses.
package semaphore_pkg;

    localparam int DATA_W = 4;   // width of one semaphore slot value
    localparam int ADDR_W = 8;   // per-core slot address width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } sem_state_t;

    // Total number of semaphore slots across all cores.
    function automatic int slot_count(input int n_sem, input int n_cores);
        return n_sem * n_cores;
    endfunction

endpackage

// File: rtl/semaphore_rr_arbiter.sv
// Round-robin arbiter: picks the first pending core after the last granted one.
// Purely combinational; the caller owns the last-granted pointer.
module semaphore_rr_arbiter #(
    parameter  int NumberOfCores = 2,
    localparam int IW            = (NumberOfCores > 1) ? $clog2(NumberOfCores) : 1
) (
    input  logic [NumberOfCores-1:0] i_pending,
    input  logic [IW-1:0]            i_last,
    output logic [NumberOfCores-1:0] o_grant
);

    logic [IW-1:0] w_idx;
    logic          w_found;

    // Walk cores starting one past the last grant; the first pending one wins.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= NumberOfCores; i++) begin
            w_idx = IW'((int'(i_last) + i) % NumberOfCores);
            if (!w_found && i_pending[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/semaphore_read_responder.sv
// Multi-core semaphore read responder. Each core posts one outstanding read;
// requests are served one at a time in round-robin order through a
// three-state IDLE -> READ -> RESP sequence.
module semaphore_read_responder
    import semaphore_pkg::*;
#(
    parameter int NumberOfSemaphores = 4,
    parameter int NumberOfCores      = 2
) (
    input  logic                                                          SEMAPHOREREADER_CLK,
    input  logic                                                          SEMAPHOREREADER_RST,
    input  logic [NumberOfCores-1:0]                                      SEMAPHOREREADER_RD_fromCPU,
    input  logic [ADDR_W*NumberOfCores-1:0]                               SEMAPHOREREADER_Addr_fromCPU,
    output logic [NumberOfCores-1:0]                                      SEMAPHOREREADER_Ready_toCPU,
    output logic [slot_count(NumberOfSemaphores, NumberOfCores)-1:0]      SEMAPHOREREADER_RD_toSemaphore,
    input  logic [DATA_W*slot_count(NumberOfSemaphores, NumberOfCores)-1:0] SEMAPHOREREADER_Data_fromSemaphore,
    output logic [NumberOfCores-1:0]                                      SEMAPHOREREADER_Valid_toCPU,
    output logic [DATA_W-1:0]                                             SEMAPHOREREADER_Data_toCPU,
    output logic                                                          SEMAPHOREREADER_Err_toCPU
);

    localparam int S  = slot_count(NumberOfSemaphores, NumberOfCores);
    localparam int IW = (NumberOfCores > 1) ? $clog2(NumberOfCores) : 1;

    sem_state_t                                r_state;
    sem_state_t                                w_next_state;
    logic [NumberOfCores-1:0]                  r_pending;
    logic [NumberOfCores-1:0][ADDR_W-1:0]      r_addr;
    logic [NumberOfCores-1:0]                  r_grant;
    logic [IW-1:0]                             r_gidx;
    logic [IW-1:0]                             r_last;
    logic [NumberOfCores-1:0]                  r_valid;
    logic [DATA_W-1:0]                         r_data;
    logic                                      r_err;

    logic                                      w_grant_load;
    logic                                      w_read_done;
    logic                                      w_resp_done;
    logic [NumberOfCores-1:0]                  w_cap;
    logic [NumberOfCores-1:0]                  w_clr;
    logic [NumberOfCores-1:0]                  w_arb_grant;
    logic [IW-1:0]                             w_arb_idx;
    logic [ADDR_W-1:0]                         w_addr;
    logic                                      w_in_range;
    logic [S-1:0]                              w_slot_hit;
    logic [DATA_W-1:0]                         w_slot_data;

    semaphore_rr_arbiter #(
        .NumberOfCores(NumberOfCores)
    ) u_arb (
        .i_pending(r_pending),
        .i_last   (r_last),
        .o_grant  (w_arb_grant)
    );

    // Only cores that are idle (Ready high) can post; busy cores' pulses are dropped.
    assign w_cap = SEMAPHOREREADER_RD_fromCPU & ~r_pending;
    assign w_clr = w_resp_done ? r_grant : '0;

    // Encode the arbiter's one-hot grant into a core index.
    always_comb begin
        w_arb_idx = '0;
        for (int c = 0; c < NumberOfCores; c++) begin
            if (w_arb_grant[c]) w_arb_idx = IW'(c);
        end
    end

    // Decode the granted core's address into a slot strobe and pick that slot's value.
    always_comb begin
        w_addr      = r_addr[r_gidx];
        w_slot_hit  = '0;
        w_slot_data = '0;
        for (int k = 0; k < S; k++) begin
            if (w_addr == ADDR_W'(k)) begin
                w_slot_hit[k] = 1'b1;
                w_slot_data   = SEMAPHOREREADER_Data_fromSemaphore[DATA_W*k +: DATA_W];
            end
        end
    end

    assign w_in_range = ({24'd0, w_addr} < 32'(S));

    // FSM state register.
    always_ff @(posedge SEMAPHOREREADER_CLK) begin
        if (SEMAPHOREREADER_RST) r_state <= ST_IDLE;
        else                     r_state <= w_next_state;
    end

    // FSM next-state and per-state control strobes.
    always_comb begin
        w_next_state = r_state;
        w_grant_load = 1'b0;
        w_read_done  = 1'b0;
        w_resp_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_grant_load = 1'b1;
                    w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                w_read_done  = 1'b1;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                w_resp_done  = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request capture, grant latch, response registers and round-robin pointer.
    always_ff @(posedge SEMAPHOREREADER_CLK) begin
        if (SEMAPHOREREADER_RST) begin
            r_pending <= '0;
            r_addr    <= '0;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_last    <= IW'(NumberOfCores - 1);
            r_valid   <= '0;
            r_data    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_cap;
            for (int c = 0; c < NumberOfCores; c++) begin
                if (w_cap[c]) r_addr[c] <= SEMAPHOREREADER_Addr_fromCPU[ADDR_W*c +: ADDR_W];
            end
            if (w_grant_load) begin
                r_grant <= w_arb_grant;
                r_gidx  <= w_arb_idx;
            end
            // Slot value is sampled only here, at the end of READ.
            if (w_read_done) begin
                r_data  <= w_in_range ? w_slot_data : '0;
                r_err   <= ~w_in_range;
                r_valid <= r_grant;
            end else begin
                r_valid <= '0;
            end
            if (w_resp_done) r_last <= r_gidx;
        end
    end

    assign SEMAPHOREREADER_Ready_toCPU    = ~r_pending;
    assign SEMAPHOREREADER_RD_toSemaphore = (r_state == ST_READ) ? w_slot_hit : '0;
    assign SEMAPHOREREADER_Valid_toCPU    = r_valid;
    assign SEMAPHOREREADER_Data_toCPU     = r_data;
    assign SEMAPHOREREADER_Err_toCPU      = r_err;

endmodule

// File: tb/tb_semaphore_read_responder.sv
// Scoreboard bench for semaphore_read_responder (4 semaphores x 2 cores = 8 slots).
module tb_semaphore_read_responder;

    typedef struct packed {
        logic [1:0] vld;
        logic [3:0] data;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rd = 2'b00;
    logic [15:0] addr = 16'd0;
    logic [1:0]  ready;
    logic [7:0]  rd_sem;
    logic [31:0] sem_data;
    logic [1:0]  valid;
    logic [3:0]  data;
    logic        err;

    exp_t q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_cyc[2];
    bit   t35 = 1'b0;

    semaphore_read_responder #(
        .NumberOfSemaphores(4),
        .NumberOfCores     (2)
    ) dut (
        .SEMAPHOREREADER_CLK               (clk),
        .SEMAPHOREREADER_RST               (rst),
        .SEMAPHOREREADER_RD_fromCPU        (rd),
        .SEMAPHOREREADER_Addr_fromCPU      (addr),
        .SEMAPHOREREADER_Ready_toCPU       (ready),
        .SEMAPHOREREADER_RD_toSemaphore    (rd_sem),
        .SEMAPHOREREADER_Data_fromSemaphore(sem_data),
        .SEMAPHOREREADER_Valid_toCPU       (valid),
        .SEMAPHOREREADER_Data_toCPU        (data),
        .SEMAPHOREREADER_Err_toCPU         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every response strobe is matched against the head of the queue.
    always @(negedge clk) begin
        if (!rst && valid != 2'b00) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", {30'd0, valid}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("resp_valid", {30'd0, valid}, {30'd0, e.vld});
                chk("resp_data",  {28'd0, data},  {28'd0, e.data});
                chk("resp_err",   {31'd0, err},   {31'd0, e.err});
            end
            for (int c = 0; c < 2; c++) begin
                if (valid[c]) begin
                    if (t35 && last_cyc[c] >= 0) chk("rr_wait_le6", {31'd0, (cyc - last_cyc[c]) <= 6}, 32'd1);
                    last_cyc[c] = cyc;
                end
            end
        end
    end

    // Drive a one-cycle request; returns just after the capture edge.
    task automatic issue(input logic [1:0] mask, input logic [7:0] a0, input logic [7:0] a1);
        @(posedge clk); #1;
        rd   = mask;
        addr = {a1, a0};
        @(posedge clk); #1;
        rd   = 2'b00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // slot k holds 15-k: slot5=A, slot1=E, slot6=9, slot3=C, slot2=D, slot4=B
        for (int k = 0; k < 8; k++) sem_data[4*k +: 4] = 4'(15 - k);
        last_cyc[0] = -1;
        last_cyc[1] = -1;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {30'd0, ready}, 32'h3);
        chk("rst_valid", {30'd0, valid}, 32'h0);
        chk("rst_rdsem", {24'd0, rd_sem}, 32'h0);
        chk("rst_data",  {28'd0, data}, 32'h0);
        chk("rst_err",   {31'd0, err}, 32'h0);

        // Single read, core0 addr 5
        q.push_back('{2'b01, 4'hA, 1'b0});
        issue(2'b01, 8'd5, 8'd0);
        @(negedge clk); chk("t031_rdsem_e0", {24'd0, rd_sem}, 32'h0);
                        chk("t031_ready_busy", {30'd0, ready}, 32'h2);
        @(negedge clk); chk("t031_rdsem_read", {24'd0, rd_sem}, 32'h20);
        @(negedge clk); chk("t031_latency", {30'd0, valid}, 32'h1);
                        chk("t031_rdsem_off", {24'd0, rd_sem}, 32'h0);
        @(negedge clk); chk("t031_valid_once", {30'd0, valid}, 32'h0);
                        chk("t031_ready_back", {30'd0, ready}, 32'h3);

        // Out-of-range, core1 addr 200
        q.push_back('{2'b10, 4'h0, 1'b1});
        issue(2'b10, 8'd0, 8'd200);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("t033_rdsem_zero", {24'd0, rd_sem}, 32'h0);
        end
        repeat (2) @(negedge clk);

        // Simultaneous requests: core0 addr1, core1 addr6
        q.push_back('{2'b01, 4'hE, 1'b0});
        q.push_back('{2'b10, 4'h9, 1'b0});
        issue(2'b11, 8'd1, 8'd6);
        repeat (7) @(negedge clk);
        chk("t032_spacing", last_cyc[1] - last_cyc[0], 32'd3);
        chk("t032_ready", {30'd0, ready}, 32'h3);

        // Back-to-back pulses from core0; slot3 changes during READ
        q.push_back('{2'b01, 4'h1, 1'b0});
        @(posedge clk); #1;
        rd = 2'b01; addr = {8'd0, 8'd3};
        @(posedge clk); #1;
        addr = {8'd0, 8'd7};
        @(posedge clk); #1;
        rd = 2'b00;
        sem_data[12 +: 4] = 4'h1;
        repeat (2) @(posedge clk); #1;
        sem_data[12 +: 4] = 4'hC;
        repeat (4) @(negedge clk);
        chk("t034_one_resp", q.size(), 32'd0);

        // Continuous requests: c1 addr4 (B), c0 addr2 (D), alternating from core1
        t35 = 1'b1;
        last_cyc[0] = -1;
        last_cyc[1] = -1;
        for (int i = 0; i < 3; i++) begin
            q.push_back('{2'b10, 4'hB, 1'b0});
            q.push_back('{2'b01, 4'hD, 1'b0});
        end
        @(posedge clk); #1;
        rd = 2'b11; addr = {8'd4, 8'd2};
        repeat (15) @(posedge clk);
        #1 rd = 2'b00;
        repeat (8) @(negedge clk);
        t35 = 1'b0;
        chk("t035_drain", q.size(), 32'd0);

        // Reset during READ discards everything
        issue(2'b11, 8'd5, 8'd6);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t036_ready", {30'd0, ready}, 32'h3);
        chk("t036_valid", {30'd0, valid}, 32'h0);
        chk("t036_rdsem", {24'd0, rd_sem}, 32'h0);
        chk("t036_data",  {28'd0, data}, 32'h0);
        chk("t036_err",   {31'd0, err}, 32'h0);
        repeat (8) @(negedge clk);
        chk("final_queue_empty", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
